// File: rtl/csa_tree_acc.sv
// Pipelined multi-operand carry-save adder tree with optional carry-save accumulation.
// Stage 1 reduces the operands (plus the fed-back sum/carry pair) with 3:2 layers; stage 2 resolves the pair.
module csa_tree_acc #(
    parameter int WIDTH     = 8,
    parameter int NUM_OPS   = 4,
    parameter int ACC_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_OPS*WIDTH-1:0]   in_data,
    input  logic                       in_mode,
    input  logic                       in_last,
    input  logic                       clear,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ACC_WIDTH-1:0]       out_sum
);

    // Tree rows: the operands followed by the two feedback rows.
    localparam int N0 = NUM_OPS + 2;

    function automatic int rows_after(input int n, input int layers);
        int c;
        c = n;
        for (int i = 0; i < layers; i++) begin
            c = 2 * (c / 3) + (c % 3);
        end
        return c;
    endfunction

    function automatic int layer_count(input int n);
        int c;
        int l;
        c = n;
        l = 0;
        for (int i = 0; i < 32; i++) begin
            if (c > 2) begin
                c = 2 * (c / 3) + (c % 3);
                l = l + 1;
            end
        end
        return l;
    endfunction

    localparam int NL = layer_count(N0);

    generate
        if (NUM_OPS < 2 || NUM_OPS > 16) begin : g_bad_num_ops
            $error("csa_tree_acc: NUM_OPS must be in 2..16");
        end
        if (ACC_WIDTH < WIDTH + $clog2(NUM_OPS)) begin : g_bad_acc_width
            $error("csa_tree_acc: ACC_WIDTH must be >= WIDTH + clog2(NUM_OPS)");
        end
    endgenerate

    logic                 s1_valid_reg;
    logic                 s1_emit_reg;
    logic [ACC_WIDTH-1:0] s1_s_reg;
    logic [ACC_WIDTH-1:0] s1_c_reg;
    logic                 acc_active_reg;
    logic                 out_valid_reg;
    logic [ACC_WIDTH-1:0] out_sum_reg;

    logic                 adv;
    logic                 accept;
    logic                 use_fb;

    logic [ACC_WIDTH-1:0] tree [0:NL][0:N0-1];

    assign adv       = !out_valid_reg || out_ready;
    assign in_ready  = adv;
    assign accept    = in_valid && adv;
    // A clear in the accepting cycle starts a fresh group, so the feedback is dropped.
    assign use_fb    = acc_active_reg && !clear;
    assign out_valid = out_valid_reg;
    assign out_sum   = out_sum_reg;

    generate
        for (genvar gi = 0; gi < N0; gi++) begin : g_row0
            if (gi < NUM_OPS) begin : g_op
                assign tree[0][gi] = ACC_WIDTH'(in_data[gi*WIDTH +: WIDTH]);
            end else if (gi == NUM_OPS) begin : g_fb_s
                assign tree[0][gi] = use_fb ? s1_s_reg : '0;
            end else begin : g_fb_c
                assign tree[0][gi] = use_fb ? s1_c_reg : '0;
            end
        end

        for (genvar li = 0; li < NL; li++) begin : g_layer
            localparam int NIN  = rows_after(N0, li);
            localparam int NG   = NIN / 3;
            localparam int NOUT = 2 * NG + (NIN % 3);
            for (genvar gi = 0; gi < N0; gi++) begin : g_slot
                if (gi < 2 * NG) begin : g_csa
                    if (gi % 2 == 0) begin : g_sum
                        assign tree[li+1][gi] = tree[li][3*(gi/2)]
                                              ^ tree[li][3*(gi/2)+1]
                                              ^ tree[li][3*(gi/2)+2];
                    end else begin : g_carry
                        assign tree[li+1][gi] = ((tree[li][3*(gi/2)]   & tree[li][3*(gi/2)+1])
                                               | (tree[li][3*(gi/2)]   & tree[li][3*(gi/2)+2])
                                               | (tree[li][3*(gi/2)+1] & tree[li][3*(gi/2)+2])) << 1;
                    end
                end else if (gi < NOUT) begin : g_pass
                    assign tree[li+1][gi] = tree[li][3*NG + gi - 2*NG];
                end else begin : g_zero
                    assign tree[li+1][gi] = '0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg   <= 1'b0;
            s1_emit_reg    <= 1'b0;
            s1_s_reg       <= '0;
            s1_c_reg       <= '0;
            acc_active_reg <= 1'b0;
        end else if (adv) begin
            if (accept) begin
                s1_s_reg       <= tree[NL][0];
                s1_c_reg       <= tree[NL][1];
                s1_valid_reg   <= 1'b1;
                s1_emit_reg    <= !in_mode || in_last;
                acc_active_reg <= in_mode && !in_last;
            end else begin
                s1_valid_reg <= 1'b0;
                if (clear) begin
                    acc_active_reg <= 1'b0;
                    s1_s_reg       <= '0;
                    s1_c_reg       <= '0;
                end
            end
        end else if (clear) begin
            // Stalled: keep a result still waiting for stage 2, only end the group.
            acc_active_reg <= 1'b0;
            if (!(s1_valid_reg && s1_emit_reg)) begin
                s1_s_reg <= '0;
                s1_c_reg <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_sum_reg   <= '0;
        end else if (adv) begin
            if (s1_valid_reg && s1_emit_reg) begin
                out_sum_reg   <= s1_s_reg + s1_c_reg;
                out_valid_reg <= 1'b1;
            end else begin
                out_valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_csa_tree_acc.sv
// Directed bench for csa_tree_acc: a group-level arithmetic model checked every cycle, plus literal results.
module tb_csa_tree_acc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_mode = 1'b0;
    logic        in_last = 1'b0;
    logic        clear = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_sum;

    int checks = 0;
    int failures = 0;
    int exp_q[$];
    int outs[$];
    int run_total = 0;
    bit grp_open = 1'b0;
    int n0;

    csa_tree_acc #(.WIDTH(8), .NUM_OPS(4), .ACC_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .in_last(in_last), .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [31:0] pack(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    // Model: group totals in plain integers; an emitted total is queued for the output side.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_out_valid", out_valid, 0);
            exp_q.delete();
            grp_open = 1'b0;
            run_total = 0;
        end else begin
            chk("in_ready", in_ready, (!out_valid || out_ready) ? 1 : 0);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=%0d required=none", out_sum);
                end else begin
                    chk("out_sum", out_sum, exp_q[0]);
                    if (out_ready) begin
                        outs.push_back(int'(out_sum));
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) begin
                int s;
                int t;
                s = 0;
                for (int i = 0; i < 4; i++) s += int'(in_data[i*8 +: 8]);
                t = ((grp_open && !clear) ? run_total : 0) + s;
                if (!in_mode || in_last) begin
                    exp_q.push_back(t % 65536);
                    grp_open = 1'b0;
                end else begin
                    run_total = t % 65536;
                    grp_open = 1'b1;
                end
            end else if (clear) begin
                grp_open = 1'b0;
            end
        end
    end

    task automatic present(input logic [31:0] d, input logic m, input logic l, input logic c);
        in_data = d;
        in_mode = m;
        in_last = l;
        clear = c;
        in_valid = 1'b1;
    endtask

    task automatic wait_accept();
        bit got;
        int k;
        got = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            k++;
        end while (!got && k < 50);
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=not_accepted required=accepted");
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        clear = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic m, input logic l, input logic c);
        present(d, m, l, c);
        wait_accept();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        clear = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_sum", out_sum, 0);
        chk("reset_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_out_valid", out_valid, 0);

        // Single sum beat: valid for exactly one cycle, two edges after accept.
        send(pack(1, 2, 3, 4), 1'b0, 1'b0, 1'b0);
        @(negedge clk); chk("lat_first_edge_valid", out_valid, 0);
        @(negedge clk); chk("lat_second_edge_valid", out_valid, 1);
        chk("single_sum", out_sum, 10);
        @(negedge clk); chk("single_pulse_end", out_valid, 0);
        @(posedge clk); #1;

        n0 = outs.size();
        send(pack(255, 255, 255, 255), 1'b0, 1'b0, 1'b0);
        send(pack(0, 0, 0, 7), 1'b0, 1'b0, 1'b0);
        idle(4);
        chk("b2b_count", outs.size() - n0, 2);
        chk("b2b_first", outs[n0], 1020);
        chk("b2b_second", outs[n0+1], 7);

        n0 = outs.size();
        send(pack(1, 1, 1, 1), 1'b1, 1'b0, 1'b0);
        send(pack(2, 2, 2, 2), 1'b1, 1'b0, 1'b0);
        send(pack(3, 3, 3, 3), 1'b1, 1'b1, 1'b0);
        idle(4);
        chk("acc_count", outs.size() - n0, 1);
        chk("acc_total", outs[n0], 24);
        send(pack(1, 0, 0, 0), 1'b0, 1'b0, 1'b0);
        idle(4);
        chk("after_acc_sum", outs[outs.size()-1], 1);

        // Backpressure: third beat must wait while result 5 is held.
        n0 = outs.size();
        out_ready = 1'b0;
        send(pack(5, 0, 0, 0), 1'b0, 1'b0, 1'b0);
        send(pack(6, 0, 0, 0), 1'b0, 1'b0, 1'b0);
        present(pack(7, 0, 0, 0), 1'b0, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_hold", out_sum, 5);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_accept();
        idle(5);
        chk("bp_count", outs.size() - n0, 3);
        chk("bp_first", outs[n0], 5);
        chk("bp_second", outs[n0+1], 6);
        chk("bp_third", outs[n0+2], 7);

        n0 = outs.size();
        for (int i = 0; i < 65; i++) send(pack(255, 255, 255, 255), 1'b1, (i == 64), 1'b0);
        idle(4);
        chk("wrap_count", outs.size() - n0, 1);
        chk("wrap_total", outs[n0], 764);

        n0 = outs.size();
        send(pack(3, 3, 3, 3), 1'b1, 1'b0, 1'b0);
        send(pack(1, 1, 1, 1), 1'b0, 1'b0, 1'b0);
        idle(4);
        chk("mode_switch", outs[outs.size()-1], 16);

        send(pack(10, 0, 0, 0), 1'b1, 1'b0, 1'b0);
        send(pack(1, 0, 0, 0), 1'b1, 1'b1, 1'b1);
        idle(4);
        chk("clear_with_beat", outs[outs.size()-1], 1);

        send(pack(3, 0, 0, 0), 1'b1, 1'b0, 1'b0);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        send(pack(4, 0, 0, 0), 1'b1, 1'b1, 1'b0);
        idle(4);
        chk("clear_idle", outs[outs.size()-1], 4);

        // Reset mid-group with a closing beat still in stage 1: nothing may emerge.
        n0 = outs.size();
        send(pack(5, 0, 0, 0), 1'b1, 1'b0, 1'b0);
        send(pack(9, 0, 0, 0), 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(pack(2, 0, 0, 0), 1'b1, 1'b1, 1'b0);
        idle(4);
        chk("reset_count", outs.size() - n0, 1);
        chk("reset_fresh", outs[outs.size()-1], 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
